// File: rtl/mmio_timer_responder_pkg.sv
// Shared constants for the MMIO timer responder: word offsets, CTRL bit
// positions and the default window base.
package mmio_timer_responder_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0400;

    localparam logic [2:0] OFF_LED     = 3'd0;
    localparam logic [2:0] OFF_CYC_LO  = 3'd1;
    localparam logic [2:0] OFF_CYC_HI  = 3'd2;
    localparam logic [2:0] OFF_LOAD    = 3'd3;
    localparam logic [2:0] OFF_VALUE   = 3'd4;
    localparam logic [2:0] OFF_CTRL    = 3'd5;
    localparam logic [2:0] OFF_STATUS  = 3'd6;
    localparam logic [2:0] OFF_SCRATCH = 3'd7;

    localparam int CTRL_W       = 3;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_AUTO    = 2;

endpackage

// File: rtl/mmio_timer_core.sv
// Down-counting timer: load/value/ctrl/expired plus decrement, reload and
// one-shot stop logic.
module mmio_timer_core
    import mmio_timer_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_load,
    input  logic              wr_ctrl,
    input  logic              wr_status,
    input  logic [31:0]       wdata,
    output logic [31:0]       load,
    output logic [31:0]       value,
    output logic [CTRL_W-1:0] ctrl,
    output logic              expired
);

    logic en_rise;
    logic hw_expire;

    assign en_rise   = wr_ctrl & wdata[CTRL_EN] & ~ctrl[CTRL_EN];
    assign hw_expire = ctrl[CTRL_EN] & (value == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load    <= '0;
            value   <= '0;
            ctrl    <= '0;
            expired <= 1'b0;
        end else begin
            if (wr_load) begin
                load <= wdata;
            end

            if (wr_load) begin
                value <= wdata;
            end else if (en_rise) begin
                value <= load;
            end else if (ctrl[CTRL_EN]) begin
                if (value != 32'd0) begin
                    value <= value - 32'd1;
                end else if (ctrl[CTRL_AUTO]) begin
                    value <= load;
                end
            end

            // Software write wins over the one-shot self-disable.
            if (wr_ctrl) begin
                ctrl <= wdata[CTRL_W-1:0];
            end else if (hw_expire & ~ctrl[CTRL_AUTO]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            // Hardware set wins over a same-cycle W1C.
            if (hw_expire) begin
                expired <= 1'b1;
            end else if (wr_status & wdata[0]) begin
                expired <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_timer_responder.sv
// MMIO responder on the core's data bus: address decode, zero-latency read
// mux, LED, 64-bit cycle counter with coherent high-word shadow, scratch.
module mmio_timer_responder
    import mmio_timer_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int          LED_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             W_en,
    input  logic             R_en,
    input  logic [31:0]      addr,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic             hit,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    logic [2:0]        off;
    logic              wr;
    logic              rd;
    logic [63:0]       cyc_cnt;
    logic [31:0]       hi_shadow;
    logic [31:0]       scratch;
    logic [31:0]       rdata;
    logic [31:0]       tmr_load;
    logic [31:0]       tmr_value;
    logic [CTRL_W-1:0] tmr_ctrl;
    logic              tmr_expired;
    logic [1:0]        unused_addr_lsb;

    assign unused_addr_lsb = addr[1:0];

    assign hit = (addr[31:5] == BASE_ADDR[31:5]);
    assign off = addr[4:2];
    assign wr  = W_en & hit;
    assign rd  = R_en & hit;

    mmio_timer_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_load   (wr && (off == OFF_LOAD)),
        .wr_ctrl   (wr && (off == OFF_CTRL)),
        .wr_status (wr && (off == OFF_STATUS)),
        .wdata     (din),
        .load      (tmr_load),
        .value     (tmr_value),
        .ctrl      (tmr_ctrl),
        .expired   (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led       <= '0;
            cyc_cnt   <= '0;
            hi_shadow <= '0;
            scratch   <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
            // Snapshot the high word alongside a low-word read so LO,HI pairs agree.
            if (rd && (off == OFF_CYC_LO)) begin
                hi_shadow <= cyc_cnt[63:32];
            end
            if (wr && (off == OFF_LED)) begin
                led <= din[LED_W-1:0];
            end
            if (wr && (off == OFF_SCRATCH)) begin
                scratch <= din;
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (off)
            OFF_LED:     rdata = 32'(led);
            OFF_CYC_LO:  rdata = cyc_cnt[31:0];
            OFF_CYC_HI:  rdata = hi_shadow;
            OFF_LOAD:    rdata = tmr_load;
            OFF_VALUE:   rdata = tmr_value;
            OFF_CTRL:    rdata = 32'(tmr_ctrl);
            OFF_STATUS:  rdata = {31'd0, tmr_expired};
            OFF_SCRATCH: rdata = scratch;
            default:     rdata = '0;
        endcase
    end

    assign dout = rd ? rdata : 32'd0;
    assign irq  = tmr_expired & tmr_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Self-checking bench for mmio_timer_responder: register-map vector table
// plus hand sequences for timer, counter coherency and async reset.
`timescale 1ns/1ps
module tb_mmio_timer_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        W_en;
    logic        R_en;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        hit;
    logic [7:0]  led;
    logic        irq;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_dout;
        logic        exp_hit;
        logic [7:0]  exp_led;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] dout;
        int          irq;
    } exp_t;

    vec_t tbl[21];
    exp_t sb[$];

    always #10 clk = ~clk;

    mmio_timer_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .W_en  (W_en),
        .R_en  (R_en),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .hit   (hit),
        .led   (led),
        .irq   (irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle, checks before the posedge.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_dout,
                          input int exp_irq, input string nm);
        exp_t e;
        W_en = w;
        R_en = r;
        addr = a;
        din  = d;
        sb.push_back('{nm: nm, dout: exp_dout, irq: exp_irq});
        #2;
        e = sb.pop_front();
        check(e.nm, dout, e.dout);
        if (e.irq >= 0) check({e.nm, ".irq"}, 32'(irq), 32'(e.irq));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lo1;
        exp_t        e;

        tbl[0]  = '{1'b0, 1'b1, 32'h400, 32'h0,         32'h0,         1'b1, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h408, 32'h0,         32'h0,         1'b1, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h40C, 32'h0,         32'h0,         1'b1, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 32'h410, 32'h0,         32'h0,         1'b1, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 32'h414, 32'h0,         32'h0,         1'b1, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 32'h418, 32'h0,         32'h0,         1'b1, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 32'h41C, 32'h0,         32'h0,         1'b1, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 32'h400, 32'hFFFF_FFA5, 32'h0,         1'b1, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 32'h400, 32'h0,         32'h0000_00A5, 1'b1, 8'hA5};
        tbl[9]  = '{1'b1, 1'b0, 32'h404, 32'h1234_5678, 32'h0,         1'b1, 8'hA5};
        tbl[10] = '{1'b0, 1'b1, 32'h403, 32'h0,         32'h0000_00A5, 1'b1, 8'hA5};
        tbl[11] = '{1'b0, 1'b1, 32'h800, 32'h0,         32'h0,         1'b0, 8'hA5};
        tbl[12] = '{1'b1, 1'b0, 32'h41C, 32'hDEAD_BEEF, 32'h0,         1'b1, 8'hA5};
        tbl[13] = '{1'b0, 1'b0, 32'h41C, 32'h0,         32'h0,         1'b1, 8'hA5};
        tbl[14] = '{1'b0, 1'b1, 32'h41C, 32'h0,         32'hDEAD_BEEF, 1'b1, 8'hA5};
        tbl[15] = '{1'b1, 1'b1, 32'h41C, 32'h1111_2222, 32'hDEAD_BEEF, 1'b1, 8'hA5};
        tbl[16] = '{1'b0, 1'b1, 32'h41C, 32'h0,         32'h1111_2222, 1'b1, 8'hA5};
        tbl[17] = '{1'b1, 1'b0, 32'h414, 32'hFFFF_FFF8, 32'h0,         1'b1, 8'hA5};
        tbl[18] = '{1'b0, 1'b1, 32'h414, 32'h0,         32'h0,         1'b1, 8'hA5};
        tbl[19] = '{1'b1, 1'b1, 32'h400, 32'h0000_003C, 32'h0000_00A5, 1'b1, 8'hA5};
        tbl[20] = '{1'b0, 1'b1, 32'h400, 32'h0,         32'h0000_003C, 1'b1, 8'h3C};

        // Reset
        rst_n = 1'b0;
        W_en  = 1'b0;
        R_en  = 1'b1;
        addr  = 32'h404;
        din   = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_led", 32'(led), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_dout", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        lo1 = dout;
        check("cyc_lo_small", 32'(lo1 < 32'd16), 32'h1);
        @(negedge clk);
        #2;
        check("cyc_lo_count", dout, lo1 + 32'd1);
        @(negedge clk);

        // Register-map vectors
        for (int i = 0; i < 21; i++) begin
            W_en = tbl[i].w;
            R_en = tbl[i].r;
            addr = tbl[i].a;
            din  = tbl[i].d;
            sb.push_back('{nm: $sformatf("vec%0d", i), dout: tbl[i].exp_dout, irq: -1});
            #2;
            e = sb.pop_front();
            check(e.nm, dout, e.dout);
            check($sformatf("vec%0d.hit", i), 32'(hit), 32'(tbl[i].exp_hit));
            check($sformatf("vec%0d.led", i), 32'(led), 32'(tbl[i].exp_led));
            @(negedge clk);
        end

        // One-shot timer
        access(1, 0, 32'h40C, 32'd3, 32'h0, 0, "os_load");
        access(1, 0, 32'h414, 32'h3, 32'h0, 0, "os_ctrl");
        access(0, 1, 32'h410, 32'h0, 32'd3, 0, "os_v3");
        access(0, 1, 32'h410, 32'h0, 32'd2, 0, "os_v2");
        access(0, 1, 32'h410, 32'h0, 32'd1, 0, "os_v1");
        access(0, 1, 32'h410, 32'h0, 32'd0, 0, "os_v0");
        access(0, 1, 32'h418, 32'h0, 32'h1, 1, "os_expired");
        access(0, 1, 32'h414, 32'h0, 32'h2, 1, "os_en_clr");
        access(1, 0, 32'h418, 32'h0, 32'h0, 1, "os_w0_status");
        access(0, 1, 32'h418, 32'h0, 32'h1, 1, "os_still_exp");
        access(1, 0, 32'h418, 32'h1, 32'h0, 1, "os_w1c");
        access(0, 1, 32'h418, 32'h0, 32'h0, 0, "os_cleared");

        // Software CTRL write beats hardware en-clear
        access(1, 0, 32'h40C, 32'd1, 32'h0, 0, "pr_load");
        access(1, 0, 32'h414, 32'h1, 32'h0, 0, "pr_ctrl");
        access(0, 1, 32'h410, 32'h0, 32'd1, 0, "pr_v1");
        access(1, 1, 32'h414, 32'h1, 32'h1, 0, "pr_sw_wins");
        access(0, 1, 32'h414, 32'h0, 32'h1, 0, "pr_en_kept");
        access(0, 1, 32'h414, 32'h0, 32'h0, 0, "pr_en_cleared");
        access(1, 0, 32'h418, 32'h1, 32'h0, 0, "pr_w1c");

        // Auto-reload, load=1: expiry every 2 cycles, hardware set beats W1C
        access(1, 0, 32'h40C, 32'd1, 32'h0, 0, "ar_load");
        access(1, 0, 32'h414, 32'h7, 32'h0, 0, "ar_ctrl");
        access(0, 1, 32'h410, 32'h0, 32'd1, 0, "ar_v1");
        access(0, 1, 32'h410, 32'h0, 32'd0, 0, "ar_v0");
        access(1, 1, 32'h418, 32'h1, 32'h1, 1, "ar_exp_w1c");
        access(1, 1, 32'h418, 32'h1, 32'h0, 0, "ar_w1c_loses");
        access(0, 1, 32'h418, 32'h0, 32'h1, 1, "ar_reexp");
        access(1, 0, 32'h414, 32'h0, 32'h0, 1, "ar_stop");
        access(1, 0, 32'h418, 32'h1, 32'h0, 0, "ar_w1c");
        access(0, 1, 32'h418, 32'h0, 32'h0, 0, "ar_clear");

        // Cycle counter LO/HI coherency across the 32-bit carry
        dut.cyc_cnt = 64'h0000_0000_FFFF_FFFF;
        access(0, 1, 32'h404, 32'h0, 32'hFFFF_FFFF, -1, "coh_lo");
        access(0, 1, 32'h408, 32'h0, 32'h0,         -1, "coh_hi");
        access(0, 1, 32'h404, 32'h0, 32'h1,         -1, "coh_lo_next");
        access(0, 1, 32'h408, 32'h0, 32'h1,         -1, "coh_hi_next");

        // Asynchronous reset mid-countdown
        access(1, 0, 32'h40C, 32'd8, 32'h0, 0, "rs_load");
        access(1, 0, 32'h414, 32'h3, 32'h0, 0, "rs_ctrl");
        access(0, 1, 32'h410, 32'h0, 32'd8, 0, "rs_v8");
        access(0, 1, 32'h410, 32'h0, 32'd7, 0, "rs_v7");
        access(0, 1, 32'h410, 32'h0, 32'd6, 0, "rs_v6");
        W_en = 1'b0;
        R_en = 1'b1;
        addr = 32'h410;
        #2;
        check("rs_v5", dout, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_value_clr", dout, 32'h0);
        addr = 32'h414;
        #1;
        check("rs_ctrl_clr", dout, 32'h0);
        check("rs_irq_clr", 32'(irq), 32'h0);
        check("rs_led_clr", 32'(led), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        R_en  = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
Data-bus responder for the single-cycle RISC-V core. It answers the same W_en/R_en/addr/din/dout load/store interface that data memory serves, but decodes a small memory-mapped I/O window instead of RAM. The window holds an LED register, a 64-bit cycle counter, a down-counting timer with interrupt, and a scratch register. It sits beside data memory at the top level; the top muxes dout using hit.

Parameters:
BASE_ADDR, 32'h0000_0400, byte base of the 32-byte register window; must be 32-byte aligned.
LED_W, 8, width of the LED output register.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
W_en  in  1  store strobe from core
R_en  in  1  load strobe from core
addr  in  32  byte address from core
din  in  32  store data
dout  out  32  load data; 0 when not hit or R_en=0
hit  out  1  addr[31:5]==BASE_ADDR[31:5]; combinational
led  out  LED_W  LED register contents
irq  out  1  timer interrupt = expired & irq_en

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low. On reset all registers clear to 0: led, cycle counter, hi_shadow, load, value, ctrl, expired, scratch. Outputs dout=0 and irq=0 while rst_n=0.
- Decode: word offset off=addr[4:2]. addr[1:0] are ignored, so every access is a full word.
- Register map by byte offset:
  - 0x00 LED: RW, bits[LED_W-1:0]; upper bits read 0.
  - 0x04 CYC_LO: RO.
  - 0x08 CYC_HI: RO, returns hi_shadow.
  - 0x0C LOAD: RW.
  - 0x10 VALUE: RO.
  - 0x14 CTRL: RW. bit0 en, bit1 irq_en, bit2 auto_reload; other bits read 0.
  - 0x18 STATUS: bit0 expired; writing 1 clears it, writing 0 has no effect.
  - 0x1C SCRATCH: RW.
- Read path: combinational, zero latency. dout = reg[off] when R_en & hit, else 0. This matches the core's same-cycle load.
- Write path: register updates at the posedge where W_en & hit. Writes to RO offsets are ignored.
- Simultaneous R_en & W_en to the same offset: dout shows the old value; the new value is visible from the next cycle.
- Cycle counter: 64-bit, free-running, +1 every cycle, wraps 2^64-1 -> 0.
  - CYC_LO read returns the current low word.
  - At the posedge of any R_en & hit & off==CYC_LO, hi_shadow <= counter[63:32] as of that same cycle. A LO-then-HI read pair is therefore coherent.
- Timer: value is 32 bits. Each cycle with en=1:
  - value!=0: value <= value-1.
  - value==0: expired <= 1. If auto_reload=1, value <= load. If auto_reload=0, en <= 0.
- Timer write rules:
  - Writing LOAD sets load and value together, same edge.
  - Writing CTRL with en going 0->1 copies load into value; this takes priority over that cycle's decrement.
  - load=0 with auto_reload=1: expired sets every enabled cycle.
- Priority on expired: hardware set beats a same-cycle W1C.
- Priority on en: a software CTRL write beats the hardware en-clear in the same cycle.
- irq = expired & irq_en, combinational from registers, so there is no added latency.
- Reset mid-operation clears the timer and counter immediately; it does not wait for a clock edge.

Decomposition:
- Shared package: register offset constants (OFF_LED ... OFF_SCRATCH), CTRL bit indices, and the BASE_ADDR default.
- One natural sub-module: mmio_timer_core, which holds load/value/ctrl/expired and the decrement/reload logic. The top level owns decode, the read mux, LED, cycle counter, hi_shadow and scratch.

Test Plan:
- Reset: hold rst_n=0, then release. led=0, irq=0. Read 0x400..0x41C with R_en=1: all return 0 except CYC_LO, which is small and counting.
- Store 0xFFFF_FFA5 to 0x400 -> led=8'hA5 next cycle; a load of 0x400 returns 0x0000_00A5. Store to 0x404 ignored. Address 0x800 -> hit=0, dout=0.
- Timer one-shot:
  - Write LOAD=3, then CTRL=0x3.
  - VALUE reads 3, 2, 1, 0 on successive cycles. Expired and irq assert the cycle after VALUE=0 is seen; en reads 0.
  - Write STATUS=1 -> irq=0.
- Timer auto-reload: LOAD=1, CTRL=0x7 -> expired re-sets every 2 cycles. A W1C issued in an expiry cycle leaves expired=1.
- Cycle coherency: force the counter to 0x0000_0000_FFFF_FFFF via backdoor. Read LO (returns 0xFFFF_FFFF), then HI: HI returns 0, not 1.
- Async reset mid-countdown: assert rst_n=0 between clock edges while VALUE=5. VALUE, ctrl and irq go 0 immediately.
